// File: rtl/ch_point_buf_if.sv
// ch_point_buf_if: point capture inputs and CPU read/status port of ch_point_buf.
// v_max_o/v_min_o exist only when CH_POINT_BUF_PEAK_EN is defined.
interface ch_point_buf_if #(
  parameter int DEPTH_LOG2 = 10,
  parameter int T_W = 10,
  parameter int V_W = 16
);
  logic point_rdy_i;
  logic [T_W-1:0] point_t_i;
  logic [V_W-1:0] point_v_i;
  logic clr_i;
  logic rd_req_i;
  logic rd_valid_o;
  logic [31:0] rd_data_o;
  logic [DEPTH_LOG2:0] count_o;
  logic empty_o;
  logic full_o;
  logic overflow_o;
  logic done_o;
`ifdef CH_POINT_BUF_PEAK_EN
  logic [V_W-1:0] v_max_o;
  logic [V_W-1:0] v_min_o;
`endif
  modport master (
    output point_rdy_i, point_t_i, point_v_i, clr_i, rd_req_i,
    input rd_valid_o, rd_data_o, count_o, empty_o, full_o, overflow_o, done_o
`ifdef CH_POINT_BUF_PEAK_EN
    , input v_max_o, v_min_o
`endif
  );
  modport slave (
    input point_rdy_i, point_t_i, point_v_i, clr_i, rd_req_i,
    output rd_valid_o, rd_data_o, count_o, empty_o, full_o, overflow_o, done_o
`ifdef CH_POINT_BUF_PEAK_EN
    , output v_max_o, v_min_o
`endif
  );
endinterface

// File: rtl/ch_point_buf.sv
// ch_point_buf: FIFO of (time code, voltage) points read by the CPU as 32-bit words.
// Optional CH_POINT_BUF_PEAK_EN adds running v_max_o/v_min_o of accepted points.
module ch_point_buf #(
  parameter int DEPTH_LOG2 = 10,
  parameter int T_W = 10,
  parameter int V_W = 16,
  parameter int T_LAST = 1023
) (
  input logic clk_i,
  input logic arst_i,
  ch_point_buf_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int W = T_W + V_W;
  localparam int CW = DEPTH_LOG2 + 1;
  logic [W-1:0] mem_q [DEPTH];
  logic rdy_q, wr_q, rv_q, ovf_q, done_q;
  logic [T_W-1:0] t_q;
  logic [V_W-1:0] v_q;
  logic [DEPTH_LOG2-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] rd_q;
  logic edge_seen, full, empty, wr_ok, wr_drop, rd_ok;
`ifdef CH_POINT_BUF_PEAK_EN
  logic [V_W-1:0] vmax_q, vmin_q;
  assign bus.v_max_o = vmax_q;
  assign bus.v_min_o = vmin_q;
`endif
  always_comb begin
    edge_seen = bus.point_rdy_i & ~rdy_q;
    full = cnt_q[DEPTH_LOG2];
    empty = cnt_q == '0;
    wr_ok = wr_q & ~full & ~bus.clr_i;
    wr_drop = wr_q & full & ~bus.clr_i;
    rd_ok = bus.rd_req_i & ~empty & ~bus.clr_i;
    cnt_d = cnt_q + CW'(wr_ok) - CW'(rd_ok);
  end
  always_ff @(posedge clk_i) begin
    if (wr_ok) mem_q[wp_q] <= {t_q, v_q};
  end
  // a point waits one cycle in t_q/v_q so the full test sees the count at write time
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      rdy_q <= 1'b0;
      wr_q <= 1'b0;
      t_q <= '0;
      v_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      rv_q <= 1'b0;
      rd_q <= '0;
      ovf_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rdy_q <= bus.point_rdy_i;
      wr_q <= edge_seen & ~bus.clr_i;
      if (edge_seen) begin
        t_q <= bus.point_t_i;
        v_q <= bus.point_v_i;
      end
      rv_q <= rd_ok;
      if (rd_ok) rd_q <= 32'(mem_q[rp_q]);
      if (bus.clr_i) begin
        wp_q <= '0;
        rp_q <= '0;
        cnt_q <= '0;
        ovf_q <= 1'b0;
        done_q <= 1'b0;
      end else begin
        wp_q <= wr_ok ? wp_q + DEPTH_LOG2'(1) : wp_q;
        rp_q <= rd_ok ? rp_q + DEPTH_LOG2'(1) : rp_q;
        cnt_q <= cnt_d;
        ovf_q <= ovf_q | wr_drop;
        done_q <= done_q | (wr_ok & (t_q == T_W'(T_LAST)));
      end
    end
  end
`ifdef CH_POINT_BUF_PEAK_EN
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      vmax_q <= '0;
      vmin_q <= '1;
    end else if (bus.clr_i) begin
      vmax_q <= '0;
      vmin_q <= '1;
    end else if (wr_ok) begin
      vmax_q <= v_q > vmax_q ? v_q : vmax_q;
      vmin_q <= v_q < vmin_q ? v_q : vmin_q;
    end
  end
`endif
  assign bus.rd_valid_o = rv_q;
  assign bus.rd_data_o = rd_q;
  assign bus.count_o = cnt_q;
  assign bus.empty_o = empty;
  assign bus.full_o = full;
  assign bus.overflow_o = ovf_q;
  assign bus.done_o = done_q;
endmodule

// File: doc/ch_point_buf.md
Name: ch_point_buf

Overview:
- Downstream consumer of the channel measure controller.
- Captures each measured (time code, threshold voltage) point the controller emits into an on-chip FIFO.
- Packs each point into a 32-bit word and exposes it to the SoC CPU through a simple request/valid read port, with fill level, overflow and sweep-done status.

Parameters:
- DEPTH_LOG2, 10, log2 of FIFO depth in points (default 1024 entries = one full delay-code sweep).
- T_W, 10, width of the point time code (delay-line code).
- V_W, 16, width of the point voltage (threshold code).
- T_LAST, 1023, time code that marks the final point of a sweep.

Ports:
- clk_i  in  1  system clock.
- arst_i  in  1  reset, asynchronous, active-high.
- point_rdy_i  in  1  point strobe from the measure controller (level; a rising edge means a new point).
- point_t_i  in  T_W  point time code, stable while point_rdy_i is high.
- point_v_i  in  V_W  point voltage, stable while point_rdy_i is high.
- clr_i  in  1  synchronous flush.
- rd_req_i  in  1  read request, one word per cycle it is high.
- rd_valid_o  out  1  rd_data_o holds a valid word this cycle.
- rd_data_o  out  32  {zero pad, point_t, point_v}; v in bits [V_W-1:0], t in [V_W+T_W-1:V_W].
- count_o  out  DEPTH_LOG2+1  number of stored points.
- empty_o  out  1  count_o == 0.
- full_o  out  1  count_o == 2^DEPTH_LOG2.
- overflow_o  out  1  sticky: a point was dropped.
- done_o  out  1  sticky: a point with t == T_LAST was stored.

Behaviour:
- Reset (arst_i high, asynchronous): pointers and count = 0, rd_valid_o = 0, rd_data_o = 0, overflow_o = 0, done_o = 0, empty_o = 1, full_o = 0.
- Capture:
  - point_rdy_i is registered once; a write event is prev == 0 and cur == 1.
  - The point is written one cycle after the rising edge is seen.
  - A point_rdy_i held high produces exactly one write.
  - t and v are sampled in the same cycle as the edge detect.
- Write when full_o = 1 at the start of the cycle:
  - The point is dropped and overflow_o is set.
  - The drop applies even if a read occurs in the same cycle.
- Read:
  - rd_req_i high with empty_o = 0 pops the head word.
  - rd_valid_o = 1 and rd_data_o = word on the next cycle; latency is 1 cycle.
  - rd_req_i while empty is ignored: rd_valid_o = 0, no pointer change.
  - rd_data_o holds its last value when rd_valid_o = 0.
- Simultaneous write and read when not full and not empty: both occur and count_o is unchanged.
- Simultaneous write and read when empty: only the write occurs; the read is ignored.
- Pointers wrap modulo 2^DEPTH_LOG2.
- count_o is an explicit counter, not derived from pointer difference, so the full state is distinguishable.
- done_o:
  - Set when a write is accepted with t == T_LAST.
  - Not set if that point is dropped.
  - Stays set until clr_i or reset.
- clr_i (synchronous):
  - Next cycle: pointers = 0, count = 0, overflow_o = 0, done_o = 0, rd_valid_o = 0.
  - Priority over any write or read in the same cycle.
  - The edge-detect register still updates, so a point_rdy_i edge coincident with clr_i is lost.
- Reset asserted mid-sweep discards all contents immediately.
- Storage is an inferred synchronous-read RAM of 2^DEPTH_LOG2 x (T_W+V_W) bits.
- Flag outputs are registered or derived from registered count; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: CH_POINT_BUF_PEAK_EN.
- When defined:
  - Adds outputs v_max_o (V_W) and v_min_o (V_W), updated on every accepted write.
  - v_max_o resets to 0; v_min_o resets to all-ones.
  - clr_i restores both to their reset values.
  - Dropped points do not update them.
  - Updates are visible one cycle after the write.
- When undefined: the ports and logic are absent and the remaining behaviour is identical.

Test Plan:
- Reset, then 3 points t=0,1,2 with v=0x0010,0x0020,0x0030, then rd_req_i for 3 cycles -> rd_valid_o 1 cycle after each request; words 0x00000010, 0x00010020, 0x00020030; count 3->0; empty_o = 1.
- point_rdy_i held high for 5 cycles with t=7, v=0x1234 -> count_o = 1; one word 0x00071234.
- Fill with 1024 points t=0..1023, then one more -> full_o = 1; done_o = 1; overflow_o = 1; count_o = 1024; first read returns t=0.
- Empty FIFO; a write edge and rd_req_i in the same cycle; read issued again 2 cycles later -> first request gives no rd_valid_o; second returns the point; count ends at 0.
- clr_i with count = 5, overflow_o = 1 and done_o = 1 -> all cleared next cycle; a following read gives no rd_valid_o.
- Peak build only: points with v=0x0100, 0x00F0, 0x0200 -> v_max_o = 0x0200; v_min_o = 0x00F0.
